// File: rtl/complex_mult_driver_if.sv
// Bundles the host FIFO, multiplier handshake and status signals of complex_mult_driver.
// slave is the driver's view; master is the view of whatever surrounds it (host plus multiplier).
interface complex_mult_driver_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    wr_en;
  logic [4*DATA_WIDTH-1:0] wr_data;
  logic                    wr_full;
  logic                    op_val;
  logic                    op_ready;
  logic [4*DATA_WIDTH-1:0] op_data;
  logic                    res_val;
  logic                    res_ready;
  logic [4*DATA_WIDTH-1:0] res_data;
  logic                    rd_en;
  logic [4*DATA_WIDTH-1:0] rd_data;
  logic                    rd_empty;
  logic                    busy;
  logic [1:0]              err;

  modport slave (
    input  wr_en, wr_data, op_ready, res_val, res_data, rd_en,
    output wr_full, op_val, op_data, res_ready, rd_data, rd_empty, busy, err
  );

  modport master (
    output wr_en, wr_data, op_ready, res_val, res_data, rd_en,
    input  wr_full, op_val, op_data, res_ready, rd_data, rd_empty, busy, err
  );
endinterface

// File: rtl/complex_mult_driver.sv
// Feeds queued operand pairs to a complex multiplier one at a time and queues its results.
// Define COMPLEX_MULT_DRIVER_ERR_EN to compile in the sticky overflow/underflow flags on err.
module complex_mult_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sw_rst,
  complex_mult_driver_if.slave bus
);
  localparam int W  = 4 * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;

  logic [W-1:0]  cmd_mem_r [FIFO_DEPTH];
  logic [AW-1:0] cmd_wptr_r;
  logic [AW-1:0] cmd_rptr_r;
  logic [CW-1:0] cmd_cnt_r;
  logic [W-1:0]  res_mem_r [FIFO_DEPTH];
  logic [AW-1:0] res_wptr_r;
  logic [AW-1:0] res_rptr_r;
  logic [CW-1:0] res_cnt_r;
  logic [W-1:0]  hold_r;

  logic cmd_full_s;
  logic cmd_empty_s;
  logic res_full_s;
  logic res_empty_s;
  logic cmd_push_s;
  logic cmd_pop_s;
  logic res_push_s;
  logic res_pop_s;

  assign cmd_full_s  = (cmd_cnt_r == CNT_FULL);
  assign cmd_empty_s = (cmd_cnt_r == '0);
  assign res_full_s  = (res_cnt_r == CNT_FULL);
  assign res_empty_s = (res_cnt_r == '0);

  // An issue reserves a result slot by requiring it free before any same-cycle host pop.
  assign cmd_push_s = bus.wr_en && !cmd_full_s;
  assign cmd_pop_s  = (state_r == IDLE) && !cmd_empty_s && !res_full_s;
  assign res_push_s = (state_r == WAIT_RES) && bus.res_val;
  assign res_pop_s  = bus.rd_en && !res_empty_s;

  // FIFO storage arrays; contents are only visible through the reset pointers and counts.
  always_ff @(posedge clk) begin
    if (cmd_push_s) cmd_mem_r[cmd_wptr_r] <= bus.wr_data;
    if (res_push_s) res_mem_r[res_wptr_r] <= bus.res_data;
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_wptr_r <= '0;
      cmd_rptr_r <= '0;
      cmd_cnt_r  <= '0;
    end else if (sw_rst) begin
      cmd_wptr_r <= '0;
      cmd_rptr_r <= '0;
      cmd_cnt_r  <= '0;
    end else begin
      if (cmd_push_s) cmd_wptr_r <= cmd_wptr_r + PTR_ONE;
      if (cmd_pop_s)  cmd_rptr_r <= cmd_rptr_r + PTR_ONE;
      case ({cmd_push_s, cmd_pop_s})
        2'b10:   cmd_cnt_r <= cmd_cnt_r + CNT_ONE;
        2'b01:   cmd_cnt_r <= cmd_cnt_r - CNT_ONE;
        default: cmd_cnt_r <= cmd_cnt_r;
      endcase
    end
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_wptr_r <= '0;
      res_rptr_r <= '0;
      res_cnt_r  <= '0;
    end else if (sw_rst) begin
      res_wptr_r <= '0;
      res_rptr_r <= '0;
      res_cnt_r  <= '0;
    end else begin
      if (res_push_s) res_wptr_r <= res_wptr_r + PTR_ONE;
      if (res_pop_s)  res_rptr_r <= res_rptr_r + PTR_ONE;
      case ({res_push_s, res_pop_s})
        2'b10:   res_cnt_r <= res_cnt_r + CNT_ONE;
        2'b01:   res_cnt_r <= res_cnt_r - CNT_ONE;
        default: res_cnt_r <= res_cnt_r;
      endcase
    end
  end

  // Operand holding register, loaded from the command FIFO head at issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_r <= '0;
    end else if (sw_rst) begin
      hold_r <= '0;
    end else if (cmd_pop_s) begin
      hold_r <= cmd_mem_r[cmd_rptr_r];
    end else begin
      hold_r <= hold_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else if (sw_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_next_s  = state_r;
    bus.op_val    = 1'b0;
    bus.res_ready = 1'b0;
    bus.busy      = 1'b1;
    case (state_r)
      IDLE: begin
        bus.busy = 1'b0;
        if (cmd_pop_s) state_next_s = ISSUE;
        else           state_next_s = IDLE;
      end
      ISSUE: begin
        bus.op_val = 1'b1;
        if (bus.op_ready) state_next_s = WAIT_RES;
        else              state_next_s = ISSUE;
      end
      WAIT_RES: begin
        bus.res_ready = 1'b1;
        if (bus.res_val) state_next_s = IDLE;
        else             state_next_s = WAIT_RES;
      end
      default: begin
        bus.busy     = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // Host-facing data and flags; stale FIFO words are masked while empty.
  always_comb begin
    bus.wr_full  = cmd_full_s;
    bus.rd_empty = res_empty_s;
    bus.op_data  = hold_r;
    if (res_empty_s) bus.rd_data = '0;
    else             bus.rd_data = res_mem_r[res_rptr_r];
  end

`ifdef COMPLEX_MULT_DRIVER_ERR_EN
  logic [1:0] err_r;

  // Sticky {overflow, underflow} flags for host accesses the FIFOs refused.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_r <= 2'b00;
    end else if (sw_rst) begin
      err_r <= 2'b00;
    end else begin
      err_r <= err_r | {bus.wr_en && cmd_full_s, bus.rd_en && res_empty_s};
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 2'b00;
`endif
endmodule
